// File: rtl/game_pkg.sv
// Shared screen constants and encodings for the game datapath.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDelay   = 2'd1,
    StRepeat  = 2'd2,
    StBlocked = 2'd3
  } state_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low raw button and accepts a level only after it has been
// stable for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw_n,
  output logic pressed
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_pressed;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  assign w_level = ~r_sync2;
  assign pressed = r_pressed;

  // Counter tracks how long the synced level has disagreed with the accepted one.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_pressed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      if (w_level == r_pressed) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_pressed <= w_level;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player paddle controller: debounced buttons, press-move, hold delay, auto-repeat
// with optional acceleration, pause, and registered sprite position.
module player_motion_ctrl #(
  parameter int unsigned SCREEN_W        = game_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H        = game_pkg::SCREEN_H,
  parameter int unsigned PLAYER_W        = 32,
  parameter int unsigned PLAYER_H        = 16,
  parameter int unsigned BOTTOM_MARGIN   = 4,
  parameter int unsigned STEP            = 4,
  parameter int unsigned MAX_STEP        = 16,
  parameter int unsigned ACCEL_EN        = 1,
  parameter int unsigned ACCEL_REPEATS   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 15000000,
  parameter int unsigned REPEAT_PERIOD   = 1250000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pause,
  input  logic       left_button,
  input  logic       right_button,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       moving,
  output logic       dir,
  output logic       at_left_edge,
  output logic       at_right_edge
);
  import game_pkg::*;

  localparam logic [9:0] XMAX   = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0] X0     = 10'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [9:0] Y0     = 10'(SCREEN_H - BOTTOM_MARGIN - PLAYER_H);
  localparam logic [9:0] STEP_V = 10'(STEP);
  localparam logic [9:0] MAX_V  = 10'(MAX_STEP);
  localparam int unsigned TMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam int unsigned AW    = $clog2(ACCEL_REPEATS + 1);
  localparam logic [AW-1:0] A_LAST = AW'(ACCEL_REPEATS - 1);

  state_e        r_state, w_state_next;
  dir_e          r_dir, w_dir_next, w_move_dir;
  logic [TW-1:0] r_timer, w_timer_next, w_timer_last;
  logic [9:0]    r_x, w_x_next, r_step, w_step_next, w_x_left, w_x_right;
  logic [AW-1:0] r_acnt, w_acnt_next;
  logic [10:0]   w_sum;
  logic          r_moving, w_moving_next, w_move;
  logic          w_pl, w_pr, w_active, w_other;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .raw_n    (left_button),
    .pressed  (w_pl)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_db (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .raw_n    (right_button),
    .pressed  (w_pr)
  );

  assign w_active     = (r_dir == DirRight) ? w_pr : w_pl;
  assign w_other      = (r_dir == DirRight) ? w_pl : w_pr;
  assign w_timer_last = (r_state == StDelay) ? T_DELAY_LAST : T_PERIOD_LAST;
  assign w_sum        = {1'b0, r_x} + {1'b0, r_step};
  assign w_x_left     = ({1'b0, r_x} < {1'b0, r_step}) ? 10'd0 : r_x - r_step;
  assign w_x_right    = (w_sum > {1'b0, XMAX}) ? XMAX : w_sum[9:0];

  always_comb begin
    w_state_next = r_state;
    w_timer_next = '0;
    w_move       = 1'b0;
    w_move_dir   = r_dir;
    if (pause) begin
      if (!w_pl && !w_pr) w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pl ^ w_pr) begin
            w_move       = 1'b1;
            w_move_dir   = w_pr ? DirRight : DirLeft;
            w_state_next = StDelay;
          end else if (w_pl && w_pr) begin
            w_state_next = StBlocked;
          end
        end
        StDelay, StRepeat: begin
          if (!w_active) begin
            w_state_next = StIdle;
          end else if (w_other) begin
            w_state_next = StBlocked;
          end else if (r_timer == w_timer_last) begin
            w_move       = 1'b1;
            w_state_next = StRepeat;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        StBlocked: begin
          if (!w_pl && !w_pr) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Direction can only change on the press move out of IDLE, where the step is
  // already back at STEP, so the IDLE reset below also covers direction changes.
  always_comb begin
    w_x_next      = r_x;
    w_moving_next = 1'b0;
    w_dir_next    = r_dir;
    w_step_next   = r_step;
    w_acnt_next   = r_acnt;
    if (w_move) begin
      w_x_next      = (w_move_dir == DirRight) ? w_x_right : w_x_left;
      w_moving_next = (w_x_next != r_x);
      w_dir_next    = w_move_dir;
      if (ACCEL_EN != 0) begin
        if (r_acnt == A_LAST) begin
          w_acnt_next = '0;
          w_step_next = (r_step + STEP_V > MAX_V) ? MAX_V : r_step + STEP_V;
        end else begin
          w_acnt_next = r_acnt + 1'b1;
        end
      end
    end
    if (w_state_next == StIdle) begin
      w_step_next = STEP_V;
      w_acnt_next = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_x      <= X0;
      r_step   <= STEP_V;
      r_acnt   <= '0;
      r_moving <= 1'b0;
      r_dir    <= DirLeft;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_x      <= w_x_next;
      r_step   <= w_step_next;
      r_acnt   <= w_acnt_next;
      r_moving <= w_moving_next;
      r_dir    <= w_dir_next;
    end
  end

  assign player_x      = r_x;
  assign player_y      = Y0;
  assign moving        = r_moving;
  assign dir           = r_dir;
  assign at_left_edge  = (r_x == 10'd0);
  assign at_right_edge = (r_x == XMAX);

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Next-generation player paddle controller for the HDMI game. Takes two raw active-low push-buttons and produces the registered top-left position of the player sprite in 640x480 screen space. Compared with the previous single-step controller it adds:
- per-button synchronisation and debounce
- immediate step on press, then a hold delay and auto-repeat
- optional acceleration while held
- a pause input and edge flags
- parametrised screen, sprite and timing

Feeds the renderer and the collision logic.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PLAYER_W, 32, sprite width
PLAYER_H, 16, sprite height
BOTTOM_MARGIN, 4, gap between sprite bottom and screen bottom
STEP, 4, base step in pixels per move
MAX_STEP, 16, step ceiling when acceleration is on
ACCEL_EN, 1, 1 = step grows while held; 0 = fixed STEP
ACCEL_REPEATS, 4, number of repeat moves between step increments
DEBOUNCE_CYCLES, 500000, cycles a raw level must be stable to be accepted (10 ms)
REPEAT_DELAY, 15000000, cycles from press-move to first repeat (300 ms)
REPEAT_PERIOD, 1250000, cycles between repeat moves (25 ms)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
pause  in  1  1 = freeze position; timers held at 0
left_button  in  1  raw button, active-low, asynchronous
right_button  in  1  raw button, active-low, asynchronous
player_x  out  10  sprite left x, registered
player_y  out  10  sprite top y, registered, constant after reset
moving  out  1  1 for exactly one cycle when player_x changes
dir  out  1  direction of last move: 0 = left, 1 = right
at_left_edge  out  1  player_x == 0
at_right_edge  out  1  player_x == XMAX

Behaviour:
- Constants:
  - XMAX = SCREEN_W - PLAYER_W
  - X0 = XMAX/2, which is 304 at defaults
  - Y0 = SCREEN_H - BOTTOM_MARGIN - PLAYER_H, which is 460 at defaults
- Reset (reset = 0, asynchronous):
  - player_x = X0, player_y = Y0
  - moving = 0, dir = 0
  - at_left_edge = 0, at_right_edge = 0
  - state IDLE, all timers 0, cur_step = STEP
  - debouncers read as released
- Input path:
  - Each button goes through a 2-FF synchroniser, then the debouncer, giving press signals pl and pr (active-high).
  - A level change is accepted after DEBOUNCE_CYCLES consecutive stable cycles.
  - Any bounce resets the stability count.
- Moves are decided on the clock edge and appear on player_x and moving on the next edge (1-cycle latency).
- Left move: if player_x < cur_step then 0, else player_x - cur_step. Compare at 11 bits; no wrap.
- Right move: if player_x + cur_step > XMAX then XMAX, else the sum. Use an 11-bit sum.
- moving is asserted only if the value actually changes. A move at an edge gives moving = 0, but dir still updates.
- Whenever dir changes or the FSM enters IDLE, cur_step resets to STEP.
- FSM states:
  - IDLE
    - exactly one of pl/pr asserted: move in that direction, clear the timer, go to DELAY
    - both asserted: go to BLOCKED, no move
  - DELAY
    - timer counts up; at REPEAT_DELAY-1: move, clear the timer, go to REPEAT
  - REPEAT
    - every REPEAT_PERIOD cycles: move
    - with ACCEL_EN, every ACCEL_REPEATS moves: cur_step = min(cur_step + STEP, MAX_STEP)
  - From DELAY or REPEAT:
    - active button released: go to IDLE, no release move
    - other button also pressed: go to BLOCKED
  - BLOCKED
    - no motion
    - both released: go to IDLE
    - only one still held: stay BLOCKED; a fresh press is required
- pause = 1:
  - no moves; timers forced to 0
  - FSM held in its state, except releases are still tracked (any state with no buttons pressed goes to IDLE)
  - When pause clears while a button is held, the timer restarts from 0; there is no immediate move.
- Edge flags are combinational compares of the registered player_x.

Decomposition:
- Shared package game_pkg:
  - SCREEN_W, SCREEN_H
  - state encoding (IDLE = 0, DELAY = 1, REPEAT = 2, BLOCKED = 3)
  - dir encoding
- Sub-module button_debounce:
  - parameter DEBOUNCE_CYCLES
  - ports: CLOCK_50, reset, raw_n, pressed
  - contains the synchroniser and the stability counter
  - instantiated once per button

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, ACCEL_REPEATS=2):
1. Reset release with no buttons -> player_x = 304, player_y = 460, moving = 0, flags 0.
2. Left tap held 10 cycles, then released -> exactly one move, player_x = 300, one moving pulse, dir = 0; no extra move on release.
3. Hold right -> moves at press+1 (308), then after 20 cycles (312), then every 5 cycles; with ACCEL_EN the step goes 4,4,8,8,12,12,16,16 and stays at 16.
4. Hold left from x = 6 -> 2, then 0, then stays 0; moving = 0 on the clamped move; at_left_edge = 1. Mirror case on the right clamps at 608 with at_right_edge = 1.
5. Both pressed together, or second pressed mid-hold -> no further moves; releasing only one button gives still no moves; release both and press left -> player_x decreases by 4.
6. Raw button bouncing every 2 cycles -> no move; assert reset mid-REPEAT -> immediate return to 304 and IDLE. Pause during REPEAT -> x frozen, and the next move comes 5 cycles after pause clears.
